// File: rtl/fismos_mem_router.sv
// fismos_mem_router: PicoRV32 native-bus router with registered one-hot decode, decode-error
// responses and a sticky error register. Optional bus watchdog: FISMOS_MEM_ROUTER_TIMEOUT_EN.
module fismos_mem_router #(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hF000_0000}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_mem_valid,
  input  logic                     m_mem_instr,
  input  logic [31:0]              m_mem_addr,
  input  logic [31:0]              m_mem_wdata,
  input  logic [3:0]               m_mem_wstrb,
  output logic                     m_mem_ready,
  output logic [31:0]              m_mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_mem_valid,
  output logic                     s_mem_instr,
  output logic [31:0]              s_mem_addr,
  output logic [31:0]              s_mem_wdata,
  output logic [3:0]               s_mem_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_mem_ready,
  input  logic [NUM_SLAVES*32-1:0] s_mem_rdata,
  output logic                     bus_err,
  output logic [31:0]              err_addr,
  output logic [1:0]               err_cause,
  input  logic                     err_clear,
  output logic                     irq_err
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_cfg
    $error("fismos_mem_router: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [NUM_SLAVES-1:0] r_sel;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_instr;
  logic [31:0]           r_rdata;
  logic                  r_bus_err;
  logic [31:0]           r_err_addr;
  logic [1:0]            r_err_cause;
  logic                  r_irq;

  logic                  w_accept;
  logic                  w_in_active;
  logic                  w_hit;
  logic                  w_timeout;
  logic                  w_miss_err;
  logic                  w_capture;
  logic                  w_to_err;
  logic                  w_err_set;
  logic [1:0]            w_err_cause;
  logic                  w_done;
  logic [31:0]           w_sel_rdata;

  // Lowest matching index wins: scan downwards so lower indices overwrite higher ones.
  function automatic logic [NUM_SLAVES-1:0] f_decode(input logic [31:0] addr);
    f_decode = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        f_decode    = '0;
        f_decode[i] = 1'b1;
      end
    end
  endfunction

  assign w_accept    = (r_state == ST_IDLE) && m_mem_valid;
  assign w_in_active = (r_state == ST_ACTIVE);
  assign w_hit       = |(s_mem_ready & r_sel);

  // A decode miss latches an empty select and spends one ACTIVE cycle with no slave valid.
  assign w_miss_err  = w_in_active && (r_sel == '0);
  assign w_capture   = w_in_active && !w_miss_err && w_hit;
  assign w_to_err    = w_in_active && !w_miss_err && !w_hit && w_timeout;
  assign w_err_set   = w_miss_err | w_to_err;
  assign w_err_cause = w_miss_err ? 2'b01 : 2'b10;
  assign w_done      = w_miss_err | w_capture | w_to_err;

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = w_sel_rdata | s_mem_rdata[i*32 +: 32];
      end
    end
  end

`ifdef FISMOS_MEM_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if (w_in_active && !w_hit && !w_timeout) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_to_cnt == TO_LIM);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (m_mem_valid) w_next = ST_ACTIVE;
      ST_ACTIVE: if (w_done)      w_next = ST_RESP;
      ST_RESP:                    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_mem_valid = '0;
    m_mem_ready = 1'b0;
    case (r_state)
      ST_ACTIVE: s_mem_valid = r_sel;
      ST_RESP:   m_mem_ready = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sel       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_instr     <= 1'b0;
      r_rdata     <= '0;
      r_bus_err   <= 1'b0;
      r_err_addr  <= '0;
      r_err_cause <= 2'b00;
      r_irq       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel   <= f_decode(m_mem_addr);
        r_addr  <= m_mem_addr;
        r_wdata <= m_mem_wdata;
        r_wstrb <= m_mem_wstrb;
        r_instr <= m_mem_instr;
      end
      if (w_capture) begin
        r_rdata <= w_sel_rdata;
      end else if (w_err_set) begin
        r_rdata <= ERR_RDATA;
      end
      // A new error takes priority over a simultaneous clear.
      if (w_err_set) begin
        r_bus_err   <= 1'b1;
        r_err_addr  <= r_addr;
        r_err_cause <= w_err_cause;
      end else if (err_clear) begin
        r_bus_err   <= 1'b0;
        r_err_addr  <= '0;
        r_err_cause <= 2'b00;
      end
      r_irq <= w_err_set;
    end
  end

  assign m_mem_rdata = r_rdata;
  assign s_mem_instr = r_instr;
  assign s_mem_addr  = r_addr;
  assign s_mem_wdata = r_wdata;
  assign s_mem_wstrb = r_wstrb;
  assign bus_err     = r_bus_err;
  assign err_addr    = r_err_addr;
  assign err_cause   = r_err_cause;
  assign irq_err     = r_irq;

endmodule

// File: tb/tb_fismos_mem_router.sv
// Self-checking bench for fismos_mem_router: directed steps plus randomized accesses against a
// region-level reference model; a second instance exercises overlapping slave regions.
module tb_fismos_mem_router;

  localparam int TO = 8;
`ifdef FISMOS_MEM_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_valid, m_instr;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   sv, sr;
  logic         s_instr;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;
  logic         bus_err, irq, err_clear;
  logic [31:0]  err_addr;
  logic [1:0]   err_cause;

  logic         o_valid;
  logic [31:0]  o_addr;
  logic         o_ready;
  logic [31:0]  o_rdata;
  logic [1:0]   osv, osr;
  logic         o_s_instr;
  logic [31:0]  o_s_addr, o_s_wdata;
  logic [3:0]   o_s_wstrb;
  logic         o_bus_err, o_irq;
  logic [31:0]  o_err_addr;
  logic [1:0]   o_err_cause;

  logic [31:0]  sdata [4];
  int           lat   [4];
  bit           never [4];
  int           scnt  [4];

  int total = 0;
  int bad   = 0;
  bit          e_bus;
  logic [31:0] e_addr;
  logic [1:0]  e_cause;

  always #5 clk = ~clk;

  assign s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};

  fismos_mem_router #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .resetn(resetn),
    .m_mem_valid(m_valid), .m_mem_instr(m_instr), .m_mem_addr(m_addr),
    .m_mem_wdata(m_wdata), .m_mem_wstrb(m_wstrb),
    .m_mem_ready(m_ready), .m_mem_rdata(m_rdata),
    .s_mem_valid(sv), .s_mem_instr(s_instr), .s_mem_addr(s_addr),
    .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb),
    .s_mem_ready(sr), .s_mem_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_cause(err_cause),
    .err_clear(err_clear), .irq_err(irq)
  );

  fismos_mem_router #(.NUM_SLAVES(2), .SLAVE_BASE({32'h0000_0000, 32'h0000_0000})) u_ovl (
    .clk(clk), .resetn(resetn),
    .m_mem_valid(o_valid), .m_mem_instr(1'b0), .m_mem_addr(o_addr),
    .m_mem_wdata(32'h0), .m_mem_wstrb(4'h0),
    .m_mem_ready(o_ready), .m_mem_rdata(o_rdata),
    .s_mem_valid(osv), .s_mem_instr(o_s_instr), .s_mem_addr(o_s_addr),
    .s_mem_wdata(o_s_wdata), .s_mem_wstrb(o_s_wstrb),
    .s_mem_ready(osr), .s_mem_rdata({32'hB1B1_1111, 32'hA0A0_0000}),
    .bus_err(o_bus_err), .err_addr(o_err_addr), .err_cause(o_err_cause),
    .err_clear(1'b0), .irq_err(o_irq)
  );

  // Registered slaves: ready rises in the lat-th cycle of valid, then drops.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!resetn) begin
        sr[i]   <= 1'b0;
        scnt[i] <= 0;
      end else if (sv[i] && !sr[i]) begin
        if (!never[i] && scnt[i] + 2 >= lat[i]) sr[i] <= 1'b1;
        scnt[i] <= scnt[i] + 1;
      end else begin
        sr[i]   <= 1'b0;
        scnt[i] <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!resetn) osr <= 2'b00;
    else         osr <= osv & ~osr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Default map: region = top nibble, slaves 0..3 own regions 0..3.
  function automatic int ref_target(input logic [31:0] a);
    int region;
    region = int'(a >> 28);
    return (region < 4) ? region : -1;
  endfunction

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins, input int l, input bit nev, input logic [31:0] rd,
                        input bit drop, input bit clr);
    int          t, exp_k, got_k, irq_cnt;
    bit          to, err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sv;
    t  = ref_target(a);
    to = (t >= 0) && TO_EN && (nev || l > TO + 1);
    for (int i = 0; i < 4; i++) sdata[i] = $urandom;
    if (t >= 0) begin
      sdata[t] = rd;
      lat[t]   = l;
      never[t] = nev;
    end
    err    = (t < 0) || to;
    exp_k  = (t < 0) ? 2 : (to ? TO + 2 : l + 1);
    exp_rd = err ? 32'hDEAD_BEEF : rd;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; m_instr = ins;
    got_k   = 0;
    irq_cnt = 0;
    for (int c = 1; c <= 40 && got_k == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("s_addr", s_addr, a);
        chk("s_wdata", s_wdata, wd);
        chk("s_wstrb", {28'h0, s_wstrb}, {28'h0, ws});
        chk("s_instr", {31'h0, s_instr}, {31'h0, ins});
        if (drop) m_valid = 1'b0;
        err_clear = clr;
      end else begin
        err_clear = 1'b0;
      end
      exp_sv = (t >= 0 && c < exp_k) ? (4'b0001 << t) : 4'b0000;
      chk("s_valid", {28'h0, sv}, {28'h0, exp_sv});
      irq_cnt += int'(irq);
      if (m_ready) begin
        got_k   = c;
        m_valid = 1'b0;
      end
    end
    m_valid   = 1'b0;
    err_clear = 1'b0;
    if (clr) begin
      e_bus = 1'b0; e_addr = '0; e_cause = 2'b00;
    end
    if (err) begin
      e_bus = 1'b1; e_addr = a; e_cause = (t < 0) ? 2'b01 : 2'b10;
    end
    chk("ready_cycle", got_k, exp_k);
    chk("m_rdata", m_rdata, exp_rd);
    chk("bus_err", {31'h0, bus_err}, {31'h0, e_bus});
    chk("err_addr", err_addr, e_addr);
    chk("err_cause", {30'h0, err_cause}, {30'h0, e_cause});
    chk("irq_pulses", irq_cnt, err ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [3:0] reg4;
    resetn = 1'b0; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    err_clear = 1'b0; o_valid = 1'b0; o_addr = '0;
    for (int i = 0; i < 4; i++) begin
      sdata[i] = '0; lat[i] = 2; never[i] = 1'b0;
    end
    e_bus = 1'b0; e_addr = '0; e_cause = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_ready", {31'h0, m_ready}, 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_s_valid", {28'h0, sv}, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_wstrb", {28'h0, s_wstrb}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_cause", {30'h0, err_cause}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ovl_valid", {30'h0, osv}, 32'h0);
    resetn = 1'b1;

    access(32'h1000_0040, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0);
    access(32'h2000_0004, 32'h1234_5678, 4'b0011, 1'b0, 3, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0);
    access(32'h7000_0000, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    access(32'h3000_0010, 32'h0, 4'h0, 1'b1, 2, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1);
    access(32'h8000_0010, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    access(32'h9000_0020, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'h0, 1'b0, 1'b1);
    access(32'h0000_0080, 32'hFFFF_0000, 4'b1111, 1'b0, 4, 1'b0, 32'h0123_4567, 1'b1, 1'b0);
`ifdef FISMOS_MEM_ROUTER_TIMEOUT_EN
    access(32'h0000_0008, 32'h0, 4'h0, 1'b0, 2, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    access(32'h0000_000C, 32'h0, 4'h0, 1'b0, TO + 1, 1'b0, 32'h3333_4444, 1'b0, 1'b0);
`endif

    // Overlapping regions on the second instance: slave 0 must win.
    @(posedge clk); #1;
    o_valid = 1'b1; o_addr = 32'h0000_0100;
    @(posedge clk); #1;
    chk("ovl_s_addr", o_s_addr, 32'h0000_0100);
    chk("ovl_valid_c1", {30'h0, osv}, 32'h1);
    @(posedge clk); #1;
    chk("ovl_valid_c2", {30'h0, osv}, 32'h1);
    chk("ovl_ready_c2", {31'h0, o_ready}, 32'h0);
    @(posedge clk); #1;
    chk("ovl_valid_c3", {30'h0, osv}, 32'h0);
    chk("ovl_ready_c3", {31'h0, o_ready}, 32'h1);
    chk("ovl_rdata", o_rdata, 32'hA0A0_0000);
    chk("ovl_bus_err", {31'h0, o_bus_err}, 32'h0);
    o_valid = 1'b0;

    // Reset asserted mid-access abandons it.
    never[0] = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h0000_0020; m_wdata = '0; m_wstrb = '0; m_instr = 1'b0;
    @(posedge clk); #1;
    chk("rstact_valid_c1", {28'h0, sv}, 32'h1);
    @(posedge clk); #1;
    resetn = 1'b0; m_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    e_bus = 1'b0; e_addr = '0; e_cause = 2'b00;
    chk("rstact_valid", {28'h0, sv}, 32'h0);
    chk("rstact_ready", {31'h0, m_ready}, 32'h0);
    chk("rstact_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rstact_err_addr", err_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstact_idle_ready", {31'h0, m_ready}, 32'h0);
      chk("rstact_idle_valid", {28'h0, sv}, 32'h0);
    end
    never[0] = 1'b0;
    access(32'h2000_0100, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'h7777_8888, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int          r;
      logic [31:0] a;
      r    = int'($urandom_range(0, 5));
      reg4 = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
      a    = {reg4, 28'($urandom)};
      access(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
             1'($urandom_range(0, 1)), int'($urandom_range(2, 6)),
             TO_EN && ($urandom_range(0, 7) == 0), $urandom,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
